// File: rtl/i2c_req_arbiter_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | i2c_arb_pkg : shared types and helpers for the I2C request arbiter  |
// | Revision    : 1.0                                                   |
// +---------------------------------------------------------------------+
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } arb_state_t;

  // Index width for an NREQ-wide requester vector, never narrower than 1 bit.
  function automatic int arb_idxw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_req_arbiter_if.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | i2c_req_arbiter_if : requester bus plus controller port bundle      |
// | Revision           : 1.0                                            |
// +---------------------------------------------------------------------+
interface i2c_req_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 6
);
  logic [NREQ-1:0]           req;
  logic [NREQ-1:0]           req_rw;
  logic [NREQ*ADDRWIDTH-1:0] req_addr;
  logic [NREQ*DATAWIDTH-1:0] req_wdata;
  logic [NREQ-1:0]           gnt;
  logic [NREQ-1:0]           done;
  logic [DATAWIDTH-1:0]      rdata;
  logic                      err;
  logic                      i2c_wr_en;
  logic                      i2c_rd_en;
  logic [ADDRWIDTH-1:0]      i2c_addr;
  logic [DATAWIDTH-1:0]      i2c_wdata;
  logic                      i2c_busy;
  logic                      i2c_done;
  logic                      i2c_nack;
  logic [DATAWIDTH-1:0]      i2c_rdata;

  // Arbiter side
  modport master (
    input  req, req_rw, req_addr, req_wdata, i2c_busy, i2c_done, i2c_nack, i2c_rdata,
    output gnt, done, rdata, err, i2c_wr_en, i2c_rd_en, i2c_addr, i2c_wdata
  );

  // Requesters plus controller side
  modport slave (
    output req, req_rw, req_addr, req_wdata, i2c_busy, i2c_done, i2c_nack, i2c_rdata,
    input  gnt, done, rdata, err, i2c_wr_en, i2c_rd_en, i2c_addr, i2c_wdata
  );
endinterface
`default_nettype wire

// File: rtl/i2c_req_arbiter_rr_picker.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | rr_picker : combinational round-robin pick, first set bit at/after  |
// |             ptr_i wrapping modulo NREQ  --  Revision 1.0             |
// +---------------------------------------------------------------------+
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic            valid_o,
  output logic [IDXW-1:0] idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    // Walk from the farthest offset down so the nearest set request wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req_i[j]) idx_o = IDXW'(j);
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | i2c_req_arbiter : round-robin sequencer sharing one I2C controller  |
// |                   port among NREQ requesters  --  Revision 1.0      |
// +---------------------------------------------------------------------+
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 6,
  parameter int TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  i2c_req_arbiter_if.master      bus
);

  localparam int IDXW = arb_idxw(NREQ);
  localparam int CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_ISSUE   = ISSUE;
  localparam logic [1:0] S_WAIT    = WAIT;
  localparam logic [1:0] S_RESPOND = RESPOND;

  logic [1:0]           state_q,  state_d;
  logic [IDXW-1:0]      idx_q,    idx_d;
  logic                 rw_q,     rw_d;
  logic [CW-1:0]        cnt_q,    cnt_d;
  logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]      gnt_q,    gnt_d;
  logic [NREQ-1:0]      done_q,   done_d;
  logic                 err_q,    err_d;
  logic [DATAWIDTH-1:0] rdata_q,  rdata_d;
  logic                 wr_en_q,  wr_en_d;
  logic                 rd_en_q,  rd_en_d;
  logic [ADDRWIDTH-1:0] addr_q,   addr_d;
  logic [DATAWIDTH-1:0] wdata_q,  wdata_d;

  logic                 pick_valid;
  logic [IDXW-1:0]      pick_idx;
  logic [ADDRWIDTH-1:0] sel_addr;
  logic [DATAWIDTH-1:0] sel_wdata;

  rr_picker #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_picker (
    .req_i   (bus.req),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDXW'(i)) begin
        sel_addr  = bus.req_addr[i*ADDRWIDTH +: ADDRWIDTH];
        sel_wdata = bus.req_wdata[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rw_d     = rw_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = 1'b0;
    rdata_d  = '0;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid && !bus.i2c_busy) begin
          state_d         = S_ISSUE;
          idx_d           = pick_idx;
          rw_d            = bus.req_rw[pick_idx];
          addr_d          = sel_addr;
          wdata_d         = sel_wdata;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          rd_en_d         = bus.req_rw[pick_idx];
          wr_en_d         = !bus.req_rw[pick_idx];
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        // Completion beats timeout when both land on the same cycle.
        if (bus.i2c_done) begin
          state_d        = S_RESPOND;
          done_d[idx_q]  = 1'b1;
          err_d          = bus.i2c_nack;
          rdata_d        = rw_q ? bus.i2c_rdata : '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d        = S_RESPOND;
          done_d[idx_q]  = 1'b1;
          err_d          = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESPOND: begin
        state_d  = S_IDLE;
        gnt_d    = '0;
        rr_ptr_d = (idx_q == IDXW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      rw_q     <= 1'b0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rw_q     <= rw_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.i2c_wr_en = wr_en_q;
  assign bus.i2c_rd_en = rd_en_q;
  assign bus.i2c_addr  = addr_q;
  assign bus.i2c_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | tb_i2c_req_arbiter : directed self-checking bench, TIMEOUT=16       |
// | Revision           : 1.0                                            |
// +---------------------------------------------------------------------+
module tb_i2c_req_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  i2c_req_arbiter_if #(.NREQ(4), .DATAWIDTH(8), .ADDRWIDTH(6)) bus();

  i2c_req_arbiter #(
    .NREQ      (4),
    .DATAWIDTH (8),
    .ADDRWIDTH (6),
    .TIMEOUT   (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_gnt"},   32'(bus.gnt),       32'h0);
    chk({tag, "_done"},  32'(bus.done),      32'h0);
    chk({tag, "_err"},   32'(bus.err),       32'h0);
    chk({tag, "_wr"},    32'(bus.i2c_wr_en), 32'h0);
    chk({tag, "_rd"},    32'(bus.i2c_rd_en), 32'h0);
    chk({tag, "_addr"},  32'(bus.i2c_addr),  32'h0);
    chk({tag, "_wdata"}, 32'(bus.i2c_wdata), 32'h0);
    chk({tag, "_rdata"}, 32'(bus.rdata),     32'h0);
  endtask

  // Wait (bounded) for a strobe, then answer with an immediate i2c_done.
  task automatic serve(input string tag, input logic [31:0] exp_gnt, input logic exp_rd,
                       input logic [7:0] rdv, input logic nackv,
                       input logic [31:0] exp_rdata, input logic [31:0] exp_err);
    int n;
    n = 0;
    while (!(bus.i2c_wr_en || bus.i2c_rd_en) && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_strobe_seen"}, 32'(n < 20),        32'h1);
    chk({tag, "_gnt"},         32'(bus.gnt),       exp_gnt);
    chk({tag, "_dir"},         32'(bus.i2c_rd_en), 32'(exp_rd));
    step();
    bus.i2c_done  = 1'b1;
    bus.i2c_nack  = nackv;
    bus.i2c_rdata = rdv;
    step();
    bus.i2c_done  = 1'b0;
    bus.i2c_nack  = 1'b0;
    bus.i2c_rdata = 8'h00;
    chk({tag, "_done"},  32'(bus.done),  exp_gnt);
    chk({tag, "_rdata"}, 32'(bus.rdata), exp_rdata);
    chk({tag, "_err"},   32'(bus.err),   exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic seen;
    bus.req       = '0;
    bus.req_rw    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.i2c_busy  = 1'b0;
    bus.i2c_done  = 1'b0;
    bus.i2c_nack  = 1'b0;
    bus.i2c_rdata = '0;

    // Reset state
    repeat (3) step();
    outs_zero("rst");
    reset = 1'b1;
    step();

    // Single write from requester 0, completion 5 cycles after strobe
    bus.req_addr[0 +: 6]  = 6'h12;
    bus.req_wdata[0 +: 8] = 8'hA5;
    bus.req               = 4'b0001;
    step();
    chk("wr_strobe", 32'(bus.i2c_wr_en), 32'h1);
    chk("wr_no_rd",  32'(bus.i2c_rd_en), 32'h0);
    chk("wr_gnt",    32'(bus.gnt),       32'h1);
    chk("wr_addr",   32'(bus.i2c_addr),  32'h12);
    chk("wr_wdata",  32'(bus.i2c_wdata), 32'hA5);
    step();
    chk("wr_strobe_1cyc", 32'(bus.i2c_wr_en), 32'h0);
    repeat (3) step();
    chk("wr_nodone_yet", 32'(bus.done),     32'h0);
    chk("wr_addr_hold",  32'(bus.i2c_addr), 32'h12);
    bus.i2c_done = 1'b1;
    step();
    bus.i2c_done = 1'b0;
    chk("wr_done",     32'(bus.done), 32'h1);
    chk("wr_err",      32'(bus.err),  32'h0);
    chk("wr_gnt_resp", 32'(bus.gnt),  32'h1);
    bus.req = 4'b0000;
    step();
    chk("wr_done_1cyc", 32'(bus.done), 32'h0);
    chk("wr_gnt_drop",  32'(bus.gnt),  32'h0);

    // Single read from requester 2
    bus.req_addr[12 +: 6] = 6'h3F;
    bus.req_rw            = 4'b0100;
    bus.req               = 4'b0100;
    step();
    chk("rd_strobe", 32'(bus.i2c_rd_en), 32'h1);
    chk("rd_no_wr",  32'(bus.i2c_wr_en), 32'h0);
    chk("rd_gnt",    32'(bus.gnt),       32'h4);
    chk("rd_addr",   32'(bus.i2c_addr),  32'h3F);
    step();
    bus.i2c_done  = 1'b1;
    bus.i2c_rdata = 8'h5C;
    step();
    bus.i2c_done  = 1'b0;
    bus.i2c_rdata = 8'h00;
    chk("rd_done",  32'(bus.done),  32'h4);
    chk("rd_rdata", 32'(bus.rdata), 32'h5C);
    chk("rd_err",   32'(bus.err),   32'h0);
    bus.req    = 4'b0000;
    bus.req_rw = 4'b0000;
    step();

    // Round robin with all requesters held; pointer is at 3 after the read
    bus.req = 4'b1111;
    serve("rr_a", 32'h8, 1'b0, 8'h77, 1'b0, 32'h0, 32'h0);
    serve("rr_b", 32'h1, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0);
    serve("rr_c", 32'h2, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0);
    serve("rr_d", 32'h4, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0);
    serve("rr_e", 32'h8, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0);
    serve("rr_f", 32'h1, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0);
    bus.req = 4'b1001;
    serve("rr_skip", 32'h8, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0);
    bus.req = 4'b0000;

    // Timeout on requester 1; rdata on the bus must not leak through
    bus.req_addr[6 +: 6]  = 6'h05;
    bus.req_wdata[8 +: 8] = 8'h33;
    bus.i2c_rdata         = 8'hAA;
    bus.req               = 4'b0010;
    n = 0;
    while (!bus.i2c_wr_en && n < 20) begin
      step();
      n++;
    end
    chk("to_strobe_seen", 32'(n < 20),       32'h1);
    chk("to_gnt",         32'(bus.gnt),      32'h2);
    chk("to_wdata",       32'(bus.i2c_wdata), 32'h33);
    repeat (16) step();
    chk("to_not_early",  32'(bus.done),  32'h0);
    chk("to_gnt_hold",   32'(bus.gnt),   32'h2);
    step();
    chk("to_done",       32'(bus.done),  32'h2);
    chk("to_err",        32'(bus.err),   32'h1);
    chk("to_rdata_zero", 32'(bus.rdata), 32'h0);
    bus.req      = 4'b0000;
    bus.i2c_done = 1'b1;
    step();
    chk("stray_resp", 32'(bus.done), 32'h0);
    step();
    chk("stray_idle",   32'(bus.done), 32'h0);
    chk("stray_no_gnt", 32'(bus.gnt),  32'h0);
    bus.i2c_done  = 1'b0;
    bus.i2c_rdata = 8'h00;
    step();
    chk("stray_after", 32'(bus.done), 32'h0);

    // NACK on requester 2 (pointer now 2)
    bus.req = 4'b0100;
    serve("nack", 32'h4, 1'b0, 8'h00, 1'b1, 32'h0, 32'h1);
    bus.req = 4'b0000;

    // Busy controller holds off issue; pointer is 3 so requester 1 wins
    bus.i2c_busy = 1'b1;
    bus.req      = 4'b0010;
    seen = 1'b0;
    repeat (5) begin
      step();
      seen = seen | bus.i2c_wr_en | bus.i2c_rd_en | (|bus.gnt);
    end
    chk("busy_hold", 32'(seen), 32'h0);
    bus.i2c_busy = 1'b0;
    step();
    chk("busy_strobe", 32'(bus.i2c_wr_en), 32'h1);
    chk("busy_gnt",    32'(bus.gnt),       32'h2);

    // Asynchronous reset in WAIT abandons the transaction
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    outs_zero("arst");
    bus.req = 4'b1010;
    step();
    step();
    chk("arst_no_done", 32'(bus.done), 32'h0);
    reset = 1'b1;
    step();
    chk("rearb_gnt",  32'(bus.gnt),      32'h2);
    chk("rearb_addr", 32'(bus.i2c_addr), 32'h05);
    step();
    bus.i2c_done = 1'b1;
    step();
    bus.i2c_done = 1'b0;
    chk("rearb_done", 32'(bus.done), 32'h2);
    bus.req = 4'b0000;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_req_arbiter.md
Name: i2c_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one I2C controller port between NREQ requesters (e.g. shift-register loader, config engine, debug port).
- Latches one requester's transaction, issues a single-cycle wr_en/rd_en with addr/data to the controller, waits for completion or timeout, then returns status and read data to the winner.
- Sits between the requesters and the i2c wrapper's controller interface, replacing direct wr_en/rd_en/addr drive.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DATAWIDTH, 8, transaction data width
- ADDRWIDTH, 6, I2C register address width
- TIMEOUT, 1024, max cycles in WAIT before abort (>=2)

Ports:
- clk  input  1  system clock, all logic rising-edge
- reset  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester request level, held until its done pulse
- req_rw  input  NREQ  per-requester direction, 1=read 0=write
- req_addr  input  NREQ*ADDRWIDTH  packed addresses, requester i at [i*ADDRWIDTH +: ADDRWIDTH]
- req_wdata  input  NREQ*DATAWIDTH  packed write data, same packing
- gnt  output  NREQ  one-hot grant, high from ISSUE through RESPOND
- done  output  NREQ  one-hot, one-cycle completion pulse
- rdata  output  DATAWIDTH  read data, valid only with done
- err  output  1  timeout or NACK flag, valid only with done
- i2c_wr_en  output  1  one-cycle write strobe to controller
- i2c_rd_en  output  1  one-cycle read strobe to controller
- i2c_addr  output  ADDRWIDTH  latched address, stable from ISSUE to end of WAIT
- i2c_wdata  output  DATAWIDTH  latched write data, same stability
- i2c_busy  input  1  controller busy, no strobe issued while high
- i2c_done  input  1  one-cycle transaction-complete pulse from controller
- i2c_nack  input  1  NACK status, sampled with i2c_done
- i2c_rdata  input  DATAWIDTH  read data, sampled with i2c_done

Behaviour:
- Reset, asynchronous, while reset=0:
  - state=IDLE, rr_ptr=0.
  - gnt, done, err, strobes, i2c_addr, i2c_wdata and rdata all 0.
  - Reset mid-transaction abandons it; no done is ever produced for it.
- FSM states: IDLE, ISSUE, WAIT, RESPOND. All outputs are registered.
- IDLE:
  - If |req and !i2c_busy, pick the first set req at or after rr_ptr, wrapping modulo NREQ.
  - Latch idx, rw, addr and wdata, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE, exactly 1 cycle:
  - gnt[idx]=1.
  - i2c_rd_en=rw and i2c_wr_en=!rw; exactly one strobe is high, for this cycle only.
  - i2c_done is ignored in this state. Next state is WAIT; clear the timeout counter.
- WAIT:
  - On i2c_done: capture rdata (reads only; otherwise 0), set err=i2c_nack, go to RESPOND.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without i2c_done: err=1, rdata=0, go to RESPOND.
- RESPOND, 1 cycle:
  - done[idx]=1, err/rdata valid.
  - rr_ptr=(idx+1) mod NREQ.
  - Next state is IDLE; gnt drops on entry to IDLE.
- Minimum latency: req high at cycle 0 edge → strobe cycle 1 → i2c_done earliest cycle 2 → done cycle 3.
- No more than one transaction in flight; no back-to-back issue without an IDLE cycle.
- A requester dropping req after grant does not cancel the transaction; done is still pulsed.
- req changes on other requesters during a transaction are ignored until IDLE.
- A late i2c_done arriving in IDLE or RESPOND after a timeout is discarded.
- Timeout counter width is $clog2(TIMEOUT); the counter saturates and never wraps.
- rr_ptr wraps NREQ-1 → 0. An all-zero req leaves rr_ptr unchanged.

Decomposition:
- Package i2c_arb_pkg:
  - arb_state_t enum {IDLE, ISSUE, WAIT, RESPOND}
  - localparam IDXW=$clog2(NREQ) helper
- Sub-module rr_picker (combinational):
  - inputs: req vector and rr_ptr
  - outputs: valid and winning index
  - reusable for other shared-resource arbiters

Test Plan:
- Single write: req=4'b0001, rw=0, addr=6'h12, wdata=8'hA5; controller pulses i2c_done 5 cycles after strobe with nack=0 → i2c_wr_en is 1 cycle with addr 6'h12 and data 8'hA5; done=4'b0001 with err=0.
- Single read: req[2], rw=1, addr=6'h3F; i2c_rdata=8'h5C at i2c_done → i2c_rd_en pulse; done=4'b0100 with rdata=8'h5C and err=0.
- Round robin: req=4'b1111 held, instant done → grant order 0,1,2,3,0; req=4'b1001 after idx 0 served → next grant idx 3.
- Timeout and NACK: TIMEOUT=16 and no i2c_done → done after 16 WAIT cycles with err=1 and rdata=0; a later stray i2c_done produces no done; a separate transaction with nack=1 → err=1.
- Busy and reset: i2c_busy=1 with req=4'b0010 → no strobe until busy drops, then strobe next cycle. Assert reset in WAIT → all outputs 0 immediately; after release, the pending req is re-arbitrated from rr_ptr=0.
